flocra_axil_intr_slave: RTL
===========================

Name: flocra_axil_intr_slave

Overview:
- AXI4-Lite responder for the flocra interrupt controller, mapped at base 0x44A00000.
- Captures rising edges on up to 32 interrupt source lines into a status register and masks them with global and per-source enables.
- Drives a single registered irq line toward the PS.
- Software acknowledges with write-1-to-clear through the AXI4-Lite port.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 0x00..0x10.
- C_NUM_OF_INTR, 1, number of interrupt sources (1..32).
- C_IRQ_ACTIVE_STATE, 1, level driven on irq when asserted (1 = active-high, 0 = active-low).

Ports:
- s_axi_intr_aclk  in  1  clock
- s_axi_intr_aresetn  in  1  reset, active-low
- s_axi_intr_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s_axi_intr_awprot  in  3  ignored
- s_axi_intr_awvalid / s_axi_intr_awready  in/out  1  AW handshake
- s_axi_intr_wdata  in  32  write data
- s_axi_intr_wstrb  in  4  byte strobes
- s_axi_intr_wvalid / s_axi_intr_wready  in/out  1  W handshake
- s_axi_intr_bresp  out  2  write response
- s_axi_intr_bvalid / s_axi_intr_bready  out/in  1  B handshake
- s_axi_intr_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s_axi_intr_arprot  in  3  ignored
- s_axi_intr_arvalid / s_axi_intr_arready  in/out  1  AR handshake
- s_axi_intr_rdata  out  32  read data
- s_axi_intr_rresp  out  2  read response
- s_axi_intr_rvalid / s_axi_intr_rready  out/in  1  R handshake
- intr_src  in  C_NUM_OF_INTR  synchronous interrupt sources
- irq  out  1  interrupt request

Behaviour:
- Clocking and reset: one clock, s_axi_intr_aclk; s_axi_intr_aresetn is asynchronous assert, active-low.
- Reset values:
  - All ready/valid outputs 0; bresp = 0; rresp = 0; rdata = 0.
  - GIER, IER, ISR and the src_d edge-detect register cleared.
  - irq = ~C_IRQ_ACTIVE_STATE.
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 GIER: bit0 global enable, RW.
  - 0x04 IER: per-source enable, RW.
  - 0x08 ISR: raw latched status, RO.
  - 0x0C IAR: write-1-to-clear ISR; reads 0.
  - 0x10 IPR: ISR & IER, RO.
  - Unused bits above C_NUM_OF_INTR read 0.
- Edge capture: ISR[i] sets on any edge where intr_src[i]=1 and src_d[i]=0, independent of IER and GIER. A set and an IAR clear of the same bit in the same cycle: set wins.
- irq: registered.
  - irq = C_IRQ_ACTIVE_STATE when GIER[0] && |(ISR & IER), evaluated on the previous cycle's state.
  - Source sampled high at edge k gives ISR set at edge k and irq active after edge k+1.
- Write channel (FSM W_IDLE, W_RESP):
  - In W_IDLE, awready and wready assert together for one cycle when awvalid && wvalid are both high.
  - Register update happens in that same cycle. The FSM then moves to W_RESP with bvalid=1.
  - bvalid is held until bready, then the FSM returns to W_IDLE.
  - One outstanding write only.
  - wstrb gates bytes for GIER/IER/IAR. Writes to RO registers are ignored with bresp OKAY.
- Read channel (FSM R_IDLE, R_DATA):
  - arready pulses one cycle when arvalid is high in R_IDLE.
  - rdata and rresp are registered. rvalid=1 on the next cycle and is held, stable, until rready.
  - One outstanding read only.
- Decode errors: address > 0x10 gives SLVERR (2'b10) on bresp/rresp, the write is discarded, and rdata = 0.
- Simultaneous read and write: handled independently. A read of ISR/IPR in the same cycle as a clearing write returns the pre-write value.
- Reset mid-transaction: pending bvalid/rvalid are dropped immediately; the master must reissue.

Decomposition:
- Package flocra_intr_pkg holds:
  - Register offsets ADDR_GIER, ADDR_IER, ADDR_ISR, ADDR_IAR, ADDR_IPR.
  - RESP_OKAY and RESP_SLVERR.
  - Channel FSM state enums.
- One sub-module, flocra_intr_core: edge detect, ISR/IER/GIER storage, irq register.
- Top level contains only the AXI-Lite channel FSMs and the decode.

Test Plan:
- Reset: hold aresetn low 200 ns, then release. All valids 0, irq inactive; reads of 0x00/0x04/0x08/0x10 return 0x0.
- Basic interrupt flow (C_NUM_OF_INTR=1, active-high):
  1. Write 0x1 to 0x00, then 0x1 to 0x04.
  2. Pulse intr_src[0] for one cycle; irq goes 1 two edges later.
  3. Read 0x10 returns 0x1.
  4. Write 0x1 to 0x0C; read 0x10 returns 0x0 and irq returns to 0.
- Masking: with GIER=0, IER=0x1, pulse source. ISR reads 0x1, IPR reads 0x1, irq stays 0. Then write GIER=1 and irq asserts one cycle after the write completes.
- Collision: ack write to 0x0C with data 0x1 lands on the same edge as a new intr_src[0] rising edge. ISR[0] remains 1 and irq stays active.
- Handshake stress:
  - awvalid before wvalid by 3 cycles: no awready until wvalid is high.
  - bready held low 5 cycles: bvalid stays 1 and bresp is stable.
  - rready held low: rdata is stable.
- Decode error: write 0xFFFFFFFF to 0x14 gives bresp=2'b10 and no register changes; read 0x18 gives rresp=2'b10 and rdata=0.

Source files
------------

// File: rtl/flocra_intr_pkg.sv
// ---------------------------------------------------------------------------
// flocra_intr_pkg : register map, response codes and channel FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package flocra_intr_pkg;

  localparam logic [7:0] ADDR_GIER = 8'h00;
  localparam logic [7:0] ADDR_IER  = 8'h04;
  localparam logic [7:0] ADDR_ISR  = 8'h08;
  localparam logic [7:0] ADDR_IAR  = 8'h0C;
  localparam logic [7:0] ADDR_IPR  = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  typedef enum logic [2:0] {
    REG_GIER, REG_IER, REG_ISR, REG_IAR, REG_IPR, REG_NONE
  } reg_e;

  // Byte address to register select; the two low address bits are ignored.
  function automatic reg_e decode_addr(input logic [31:0] byte_addr);
    logic [31:0] word;
    word = byte_addr & 32'hFFFF_FFFC;
    case (word)
      32'(ADDR_GIER): return REG_GIER;
      32'(ADDR_IER):  return REG_IER;
      32'(ADDR_ISR):  return REG_ISR;
      32'(ADDR_IAR):  return REG_IAR;
      32'(ADDR_IPR):  return REG_IPR;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/flocra_intr_core.sv
// ---------------------------------------------------------------------------
// flocra_intr_core : edge capture, GIER/IER/ISR storage and registered irq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flocra_intr_core
  import flocra_intr_pkg::*;
#(
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [C_NUM_OF_INTR-1:0] intr_src_i,
  input  logic                     wr_en_i,
  input  reg_e                     wr_sel_i,
  input  logic [31:0]              wr_data_i,
  input  logic [3:0]               wr_strb_i,
  output logic                     gier_o,
  output logic [C_NUM_OF_INTR-1:0] ier_o,
  output logic [C_NUM_OF_INTR-1:0] isr_o,
  output logic                     irq_o
);

  localparam logic IRQ_ACT = 1'(C_IRQ_ACTIVE_STATE);
  localparam int   N       = C_NUM_OF_INTR;

  logic         gier_q, gier_d;
  logic [N-1:0] ier_q, ier_d;
  logic [N-1:0] isr_q, isr_d;
  logic [N-1:0] src_dly_q;
  logic         irq_q, irq_d;
  logic [31:0]  bmask;
  logic [N-1:0] clr;
  logic         unused_wdata;

  assign bmask = {{8{wr_strb_i[3]}}, {8{wr_strb_i[2]}},
                  {8{wr_strb_i[1]}}, {8{wr_strb_i[0]}}};
  assign unused_wdata = ^{wr_data_i, bmask};

  always_comb begin
    gier_d = gier_q;
    ier_d  = ier_q;
    clr    = '0;
    if (wr_en_i) begin
      case (wr_sel_i)
        REG_GIER: if (wr_strb_i[0]) gier_d = wr_data_i[0];
        REG_IER:  ier_d = (ier_q & ~bmask[N-1:0]) | (wr_data_i[N-1:0] & bmask[N-1:0]);
        REG_IAR:  clr = wr_data_i[N-1:0] & bmask[N-1:0];
        default:  ;
      endcase
    end
    // A new rising edge overrides a same-cycle acknowledge of that bit.
    isr_d = (isr_q & ~clr) | (intr_src_i & ~src_dly_q);
    irq_d = (gier_q && |(isr_q & ier_q)) ? IRQ_ACT : ~IRQ_ACT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gier_q    <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      src_dly_q <= '0;
      irq_q     <= ~IRQ_ACT;
    end else begin
      gier_q    <= gier_d;
      ier_q     <= ier_d;
      isr_q     <= isr_d;
      src_dly_q <= intr_src_i;
      irq_q     <= irq_d;
    end
  end

  assign gier_o = gier_q;
  assign ier_o  = ier_q;
  assign isr_o  = isr_q;
  assign irq_o  = irq_q;

endmodule

`default_nettype wire

// File: rtl/flocra_axil_intr_slave.sv
// ---------------------------------------------------------------------------
// flocra_axil_intr_slave : AXI4-Lite responder for the flocra interrupt block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flocra_axil_intr_slave
  import flocra_intr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                          s_axi_intr_aclk,
  input  logic                          s_axi_intr_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_intr_awaddr,
  input  logic [2:0]                    s_axi_intr_awprot,
  input  logic                          s_axi_intr_awvalid,
  output logic                          s_axi_intr_awready,
  input  logic [31:0]                   s_axi_intr_wdata,
  input  logic [3:0]                    s_axi_intr_wstrb,
  input  logic                          s_axi_intr_wvalid,
  output logic                          s_axi_intr_wready,
  output logic [1:0]                    s_axi_intr_bresp,
  output logic                          s_axi_intr_bvalid,
  input  logic                          s_axi_intr_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_intr_araddr,
  input  logic [2:0]                    s_axi_intr_arprot,
  input  logic                          s_axi_intr_arvalid,
  output logic                          s_axi_intr_arready,
  output logic [31:0]                   s_axi_intr_rdata,
  output logic [1:0]                    s_axi_intr_rresp,
  output logic                          s_axi_intr_rvalid,
  input  logic                          s_axi_intr_rready,
  input  logic [C_NUM_OF_INTR-1:0]      intr_src,
  output logic                          irq
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  reg_e                     wr_sel, rd_sel;
  logic                     wr_en;
  logic [31:0]              rd_word;
  logic                     gier;
  logic [C_NUM_OF_INTR-1:0] ier, isr;
  logic                     unused_prot;

  assign unused_prot = ^{s_axi_intr_awprot, s_axi_intr_arprot};
  assign wr_sel = decode_addr(32'(s_axi_intr_awaddr));
  assign rd_sel = decode_addr(32'(s_axi_intr_araddr));

  // awready/wready are one registered pulse; the handshake edge commits the write.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_en      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (awready_q) begin
          wr_en      = (wr_sel != REG_NONE);
          bresp_d    = (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end else if (s_axi_intr_awvalid && s_axi_intr_wvalid) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi_intr_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    case (rd_sel)
      REG_GIER: rd_word = {31'b0, gier};
      REG_IER:  rd_word = 32'(ier);
      REG_ISR:  rd_word = 32'(isr);
      REG_IPR:  rd_word = 32'(isr & ier);
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arready_q) begin
          rdata_d    = rd_word;
          rresp_d    = (rd_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end else if (s_axi_intr_arvalid) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi_intr_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi_intr_awready = awready_q;
  assign s_axi_intr_wready  = awready_q;
  assign s_axi_intr_bvalid  = bvalid_q;
  assign s_axi_intr_bresp   = bresp_q;
  assign s_axi_intr_arready = arready_q;
  assign s_axi_intr_rvalid  = rvalid_q;
  assign s_axi_intr_rresp   = rresp_q;
  assign s_axi_intr_rdata   = rdata_q;

  flocra_intr_core #(
    .C_NUM_OF_INTR      (C_NUM_OF_INTR),
    .C_IRQ_ACTIVE_STATE (C_IRQ_ACTIVE_STATE)
  ) u_core (
    .clk_i      (s_axi_intr_aclk),
    .rst_ni     (s_axi_intr_aresetn),
    .intr_src_i (intr_src),
    .wr_en_i    (wr_en),
    .wr_sel_i   (wr_sel),
    .wr_data_i  (s_axi_intr_wdata),
    .wr_strb_i  (s_axi_intr_wstrb),
    .gier_o     (gier),
    .ier_o      (ier),
    .isr_o      (isr),
    .irq_o      (irq)
  );

endmodule

`default_nettype wire
